// File: rtl/dump_sender_pkg.sv
// dump_sender_pkg: shared types and constants for the sample-dump path.
//   DATA_W       sample / UART byte width
//   Sample       one sample byte
//   UNITY_GAIN   gain code that leaves a sample unchanged (2^GAIN_SHIFT)
//   dump_state_t dump_sender FSM states
package dump_sender_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] Sample;

    localparam Sample UNITY_GAIN = Sample'(8'h80);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CORR,
        SEND,
        WAIT_TX,
        DONE
    } dump_state_t;

endpackage

// File: rtl/dump_sender_if.sv
// dump_sender_if: bundles the capture, sample-RAM, correction and UART signals
// seen by dump_sender.
//   master: the dump_sender side (drives trmt/tx_data/dump_sent/busy/overrun)
//   slave : the environment side (capture controller, sample RAM, UART)
interface dump_sender_if;
    import dump_sender_pkg::*;

    logic  send_dump;  // capture: one-cycle request, RAM address valid
    Sample ram_rdata;  // RAM data, valid the cycle after send_dump
    logic  corr_en;    // 1 = apply offset/gain correction
    Sample offset;     // signed offset
    Sample gain;       // unsigned gain, UNITY_GAIN = 1.0
    logic  tx_done;    // UART: byte fully shifted out
    logic  trmt;       // UART: start transmit
    Sample tx_data;    // UART: byte to send
    logic  dump_sent;  // capture: byte transmitted
    logic  busy;       // byte in flight
    logic  overrun;    // sticky: request arrived while busy

    modport master (
        input  send_dump, ram_rdata, corr_en, offset, gain, tx_done,
        output trmt, tx_data, dump_sent, busy, overrun
    );

    modport slave (
        output send_dump, ram_rdata, corr_en, offset, gain, tx_done,
        input  trmt, tx_data, dump_sent, busy, overrun
    );

endinterface

// File: rtl/dump_sender_sample_corrector.sv
// sample_corrector: combinational offset/gain correction with saturation.
//   raw     input  sample byte
//   offset  input  signed two's-complement offset
//   gain    input  unsigned gain, 2^GAIN_SHIFT = unity
//   corr_en input  0 passes raw through untouched
//   res     output corrected byte
module sample_corrector
    import dump_sender_pkg::*;
#(
    parameter int unsigned GAIN_SHIFT = 7
) (
    input  Sample raw,
    input  Sample offset,
    input  Sample gain,
    input  logic  corr_en,
    output Sample res
);

    // Two extra bits hold raw + offset without overflow (-128..382 for 8 bits).
    localparam int unsigned SUM_W = DATA_W + 2;

    logic signed [SUM_W-1:0]  sum;
    Sample                    s8;
    logic [2*DATA_W-1:0]      prod;
    logic [2*DATA_W-1:0]      scaled;

    always_comb begin
        sum = $signed({2'b00, raw}) + $signed({{2{offset[DATA_W-1]}}, offset});

        if (sum[SUM_W-1]) begin
            s8 = '0;
        end else if (|sum[SUM_W-2:DATA_W]) begin
            s8 = '1;
        end else begin
            s8 = sum[DATA_W-1:0];
        end

        prod   = {{DATA_W{1'b0}}, s8} * {{DATA_W{1'b0}}, gain};
        scaled = prod >> GAIN_SHIFT;

        if (!corr_en) begin
            res = raw;
        end else if (|scaled[2*DATA_W-1:DATA_W]) begin
            res = '1;
        end else begin
            res = scaled[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/dump_sender.sv
// dump_sender: moves one sample byte per capture request from sample RAM to the
// UART, applying offset/gain correction on the way.
//   clk    input  system clock (rising edge)
//   rst_n  input  asynchronous active-low reset
//   bus    dump_sender_if.master: capture request/ack, RAM data, correction
//          settings, UART trmt/tx_data/tx_done, busy and sticky overrun
// Timing: send_dump at N -> trmt at N+3; tx_done at M -> dump_sent at M+1.
module dump_sender
    import dump_sender_pkg::*;
#(
    parameter int unsigned GAIN_SHIFT = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dump_sender_if.master        bus
);

    dump_state_t state_q;
    Sample       raw_q;
    Sample       corr_res;

    // Correction settings are live inputs; they only matter in CORR, where
    // the result is captured into tx_data.
    sample_corrector #(
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_corrector (
        .raw     (raw_q),
        .offset  (bus.offset),
        .gain    (bus.gain),
        .corr_en (bus.corr_en),
        .res     (corr_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            raw_q         <= '0;
            bus.trmt      <= 1'b0;
            bus.tx_data   <= '0;
            bus.dump_sent <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.trmt      <= 1'b0;
            bus.dump_sent <= 1'b0;

            // DONE counts as idle so capture can chain the next request.
            if (bus.send_dump && (state_q != IDLE) && (state_q != DONE)) begin
                bus.overrun <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.send_dump) begin
                        state_q  <= READ;
                        bus.busy <= 1'b1;
                    end
                end
                READ: begin
                    raw_q   <= bus.ram_rdata;
                    state_q <= CORR;
                end
                CORR: begin
                    bus.tx_data <= corr_res;
                    bus.trmt    <= 1'b1;
                    state_q     <= SEND;
                end
                SEND, WAIT_TX: begin
                    if (bus.tx_done) begin
                        bus.dump_sent <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        state_q <= WAIT_TX;
                    end
                end
                DONE: begin
                    if (bus.send_dump) begin
                        state_q <= READ;
                    end else begin
                        state_q  <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dump_sender.sv
// tb_dump_sender: directed plus randomized transfers, each checked against a
// behavioural model of the correction arithmetic and the request/ack timing.
module tb_dump_sender;
    import dump_sender_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dump_sender_if bus ();

    dump_sender #(
        .GAIN_SHIFT (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int trmt_cnt = 0;
    int sent_cnt = 0;
    int exp_xfer = 0;
    bit ovr_exp  = 1'b0;

    always @(negedge clk) begin
        if (bus.trmt)      trmt_cnt++;
        if (bus.dump_sent) sent_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Correction computed straight from the arithmetic rules using integers.
    function automatic logic [7:0] ref_corr(input logic [7:0] raw, input bit en,
                                            input logic [7:0] off, input logic [7:0] g);
        int s;
        int p;
        if (!en) return raw;
        s = int'(raw) + (off[7] ? int'(off) - 256 : int'(off));
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        p = (s * int'(g)) / 128;
        if (p > 255) p = 255;
        return p[7:0];
    endfunction

    task automatic junk();
        bus.corr_en   = 1'($urandom);
        bus.offset    = 8'($urandom);
        bus.gain      = 8'($urandom);
        bus.ram_rdata = 8'($urandom);
    endtask

    // Starts at a negedge in IDLE or DONE. lat = cycles from SEND to tx_done
    // (0 = tx_done in SEND). ovr_cyc = cycle offset of a stray send_dump
    // (0 = none). chain = return in the dump_sent cycle.
    task automatic xfer(input logic [7:0] raw, input bit en, input logic [7:0] off,
                        input logic [7:0] g, input int lat, input int ovr_cyc, input bit chain);
        logic [7:0] exp;
        exp = ref_corr(raw, en, off, g);
        exp_xfer++;

        bus.send_dump = 1'b1;
        junk();
        @(negedge clk);
        bus.send_dump = (ovr_cyc == 1);
        bus.ram_rdata = raw;
        bus.tx_done   = 1'($urandom);
        check("busy_read", 32'(bus.busy), 1);
        check("trmt_read", 32'(bus.trmt), 0);

        @(negedge clk);
        bus.send_dump = (ovr_cyc == 2);
        bus.ram_rdata = 8'($urandom);
        bus.corr_en   = en;
        bus.offset    = off;
        bus.gain      = g;
        bus.tx_done   = 1'($urandom);
        check("trmt_corr", 32'(bus.trmt), 0);

        @(negedge clk);
        bus.send_dump = (ovr_cyc == 3);
        junk();
        bus.tx_done   = (lat == 0);
        check("trmt_send", 32'(bus.trmt), 1);
        check("tx_data", 32'(bus.tx_data), 32'(exp));

        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            bus.send_dump = (ovr_cyc == 3 + i);
            bus.tx_done   = (i == lat);
            check("trmt_wait", 32'(bus.trmt), 0);
            check("sent_wait", 32'(bus.dump_sent), 0);
            check("busy_wait", 32'(bus.busy), 1);
        end

        @(negedge clk);
        bus.send_dump = 1'b0;
        bus.tx_done   = 1'b0;
        if (ovr_cyc >= 1 && ovr_cyc <= 3 + lat) ovr_exp = 1'b1;
        check("dump_sent", 32'(bus.dump_sent), 1);
        check("busy_done", 32'(bus.busy), 1);
        check("overrun", 32'(bus.overrun), 32'(ovr_exp));

        if (!chain) begin
            @(negedge clk);
            check("sent_once", 32'(bus.dump_sent), 0);
            check("busy_idle", 32'(bus.busy), 0);
            check("tx_hold", 32'(bus.tx_data), 32'(exp));
        end
    endtask

    initial begin
        logic [7:0] raw;
        logic [7:0] off;
        logic [7:0] g;
        int         lat;
        int         ovr;
        bit         en;

        bus.send_dump = 1'b0;
        bus.ram_rdata = '0;
        bus.corr_en   = 1'b0;
        bus.offset    = '0;
        bus.gain      = '0;
        bus.tx_done   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_trmt", 32'(bus.trmt), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_sent", 32'(bus.dump_sent), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unity pass-through and saturation corners.
        xfer(8'h5A, 1'b1, 8'h00, UNITY_GAIN, 10, 0, 1'b0);
        xfer(8'hF0, 1'b1, 8'h20, 8'h80, 3, 0, 1'b0);
        xfer(8'h10, 1'b1, 8'hE0, 8'h80, 3, 0, 1'b0);
        xfer(8'h80, 1'b1, 8'h00, 8'hFF, 2, 0, 1'b0);
        xfer(8'h40, 1'b1, 8'h00, 8'h40, 0, 0, 1'b0);
        // Bypass ignores offset and gain.
        xfer(8'h33, 1'b0, 8'h7F, 8'h00, 1, 0, 1'b0);

        // Back-to-back requests issued in the dump_sent cycle.
        for (int i = 1; i <= 4; i++) begin
            xfer(8'(i), 1'b1, 8'h00, 8'h80, 8, 0, (i != 4));
        end
        check("b2b_overrun", 32'(bus.overrun), 0);

        // Stray request while busy, then one coinciding with tx_done.
        xfer(8'hA7, 1'b1, 8'h00, 8'h80, 5, 2, 1'b0);
        check("ovr_sticky", 32'(bus.overrun), 1);
        xfer(8'h3C, 1'b1, 8'h05, 8'h90, 4, 7, 1'b0);
        check("trmt_count", 32'(trmt_cnt), 32'(exp_xfer));
        check("sent_count", 32'(sent_cnt), 32'(exp_xfer));

        // Reset during WAIT_TX aborts the byte without a dump_sent.
        bus.send_dump = 1'b1;
        junk();
        @(negedge clk);
        bus.send_dump = 1'b0;
        bus.ram_rdata = 8'h77;
        @(negedge clk);
        bus.corr_en = 1'b1;
        bus.offset  = 8'h00;
        bus.gain    = 8'h80;
        @(negedge clk);
        check("rst_pre_trmt", 32'(bus.trmt), 1);
        @(negedge clk);
        check("rst_pre_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_trmt", 32'(bus.trmt), 0);
        check("abort_tx_data", 32'(bus.tx_data), 0);
        check("abort_sent", 32'(bus.dump_sent), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_overrun", 32'(bus.overrun), 0);
        ovr_exp = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check("abort_no_sent", 32'(bus.dump_sent), 0);
        check("abort_idle", 32'(bus.busy), 0);
        @(negedge clk);
        check("abort_no_sent2", 32'(bus.dump_sent), 0);
        xfer(8'h5A, 1'b1, 8'h00, 8'h80, 2, 0, 1'b0);

        // Randomized transfers.
        trmt_cnt = 0;
        sent_cnt = 0;
        exp_xfer = 0;
        for (int i = 0; i < 40; i++) begin
            raw = 8'($urandom);
            off = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            g   = ($urandom % 4 == 0) ? 8'h80 : 8'($urandom);
            en  = ($urandom % 4 != 0);
            lat = int'($urandom % 7);
            ovr = ($urandom % 5 == 0) ? int'($urandom_range(1, 3 + lat)) : 0;
            xfer(raw, en, off, g, lat, ovr, (i != 39) && ($urandom % 2 == 1));
        end
        @(negedge clk);
        check("rand_trmt_count", 32'(trmt_cnt), 32'(exp_xfer));
        check("rand_sent_count", 32'(sent_cnt), 32'(exp_xfer));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
